// File: rtl/ravenoc_pe_axi_mst.sv
`default_nettype none
// ============================================================================
// Module      : ravenoc_pe_axi_mst (with ravenoc_pkg)
// Description : Single-outstanding AXI4 burst master used by a processing
//               element to push packets into / drain packets from the NI.
//               Optional macro RAVENOC_PE_MST_CHECK_EN adds ID/RLAST checks.
// Revision    : 1.0 - initial release
// ============================================================================

package ravenoc_pkg;
    localparam int AXI_ADDR_WIDTH = 32;
    localparam int AXI_DATA_WIDTH = 32;
    localparam int AXI_ID_WIDTH   = 4;

    localparam logic [1:0] AXI_OKAY = 2'b00;
    localparam logic [1:0] AXI_INCR = 2'b01;

    typedef struct packed {
        logic [AXI_ID_WIDTH-1:0]     awid;
        logic [AXI_ADDR_WIDTH-1:0]   awaddr;
        logic [7:0]                  awlen;
        logic [2:0]                  awsize;
        logic [1:0]                  awburst;
        logic                        awvalid;
        logic [AXI_DATA_WIDTH-1:0]   wdata;
        logic [AXI_DATA_WIDTH/8-1:0] wstrb;
        logic                        wlast;
        logic                        wvalid;
        logic                        bready;
        logic [AXI_ID_WIDTH-1:0]     arid;
        logic [AXI_ADDR_WIDTH-1:0]   araddr;
        logic [7:0]                  arlen;
        logic [2:0]                  arsize;
        logic [1:0]                  arburst;
        logic                        arvalid;
        logic                        rready;
    } s_axi_mosi_t;

    typedef struct packed {
        logic                        awready;
        logic                        wready;
        logic [AXI_ID_WIDTH-1:0]     bid;
        logic [1:0]                  bresp;
        logic                        bvalid;
        logic                        arready;
        logic [AXI_ID_WIDTH-1:0]     rid;
        logic [AXI_DATA_WIDTH-1:0]   rdata;
        logic [1:0]                  rresp;
        logic                        rlast;
        logic                        rvalid;
    } s_axi_miso_t;
endpackage

module ravenoc_pe_axi_mst
    import ravenoc_pkg::*;
#(
    parameter int MST_ID = 0
) (
    input  logic                      clk_axi,
    input  logic                      arst_axi,
    input  logic                      cmd_valid,
    output logic                      cmd_ready,
    input  logic                      cmd_wr,
    input  logic [AXI_ADDR_WIDTH-1:0] cmd_addr,
    input  logic [7:0]                cmd_len,
    input  logic [AXI_DATA_WIDTH-1:0] wr_data,
    input  logic                      wr_valid,
    output logic                      wr_ready,
    output logic [AXI_DATA_WIDTH-1:0] rd_data,
    output logic                      rd_valid,
    input  logic                      rd_ready,
    output logic                      done,
    output logic                      err,
    output s_axi_mosi_t               axi_mosi_if,
    input  s_axi_miso_t               axi_miso_if
);

    localparam logic [AXI_ID_WIDTH-1:0] c_mst_id = AXI_ID_WIDTH'(MST_ID);
    localparam logic [2:0]              c_axsize = 3'($clog2(AXI_DATA_WIDTH/8));

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_WR_ADDR = 3'd1,
        ST_WR_DATA = 3'd2,
        ST_WR_RESP = 3'd3,
        ST_RD_ADDR = 3'd4,
        ST_RD_DATA = 3'd5,
        ST_DONE    = 3'd6
    } state_t;

    state_t                    r_state;
    logic [AXI_ADDR_WIDTH-1:0] r_addr;
    logic [7:0]                r_len;
    logic [7:0]                r_cnt;
    logic                      r_err;

    logic w_cmd_hs;
    logic w_w_hs;
    logic w_r_hs;
    logic w_last_beat;
    logic w_b_err;
    logic w_r_err;

    assign cmd_ready   = (r_state == ST_IDLE) && !arst_axi;
    assign w_cmd_hs    = cmd_valid && cmd_ready;
    assign w_last_beat = (r_cnt == r_len);
    assign w_w_hs      = (r_state == ST_WR_DATA) && wr_valid && axi_miso_if.wready;
    assign w_r_hs      = (r_state == ST_RD_DATA) && axi_miso_if.rvalid && rd_ready;

`ifdef RAVENOC_PE_MST_CHECK_EN
    // RLAST must coincide with count==len; a mismatch either way flags err.
    assign w_b_err = (axi_miso_if.bresp != AXI_OKAY) || (axi_miso_if.bid != c_mst_id);
    assign w_r_err = (axi_miso_if.rresp != AXI_OKAY) || (axi_miso_if.rid != c_mst_id) ||
                     (axi_miso_if.rlast != w_last_beat);
`else
    logic w_unused_ids;
    assign w_b_err      = (axi_miso_if.bresp != AXI_OKAY);
    assign w_r_err      = (axi_miso_if.rresp != AXI_OKAY);
    assign w_unused_ids = ^{axi_miso_if.bid, axi_miso_if.rid};
`endif

    always_ff @(posedge clk_axi or posedge arst_axi) begin
        if (arst_axi) begin
            r_state <= ST_IDLE;
            r_addr  <= '0;
            r_len   <= '0;
            r_cnt   <= '0;
            r_err   <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_cmd_hs) begin
                        r_addr  <= cmd_addr;
                        r_len   <= cmd_len;
                        r_cnt   <= '0;
                        r_err   <= 1'b0;
                        r_state <= cmd_wr ? ST_WR_ADDR : ST_RD_ADDR;
                    end
                end
                ST_WR_ADDR: begin
                    if (axi_miso_if.awready) begin
                        r_state <= ST_WR_DATA;
                    end
                end
                ST_WR_DATA: begin
                    if (w_w_hs) begin
                        if (w_last_beat) begin
                            r_state <= ST_WR_RESP;
                        end else begin
                            r_cnt <= r_cnt + 8'd1;
                        end
                    end
                end
                ST_WR_RESP: begin
                    if (axi_miso_if.bvalid) begin
                        r_err   <= r_err | w_b_err;
                        r_state <= ST_DONE;
                    end
                end
                ST_RD_ADDR: begin
                    if (axi_miso_if.arready) begin
                        r_state <= ST_RD_DATA;
                    end
                end
                ST_RD_DATA: begin
                    if (w_r_hs) begin
                        r_cnt <= r_cnt + 8'd1;
                        if (w_r_err) begin
                            r_err <= 1'b1;
                        end
                        if (axi_miso_if.rlast) begin
                            r_state <= ST_DONE;
                        end
                    end
                end
                ST_DONE: begin
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign done     = (r_state == ST_DONE);
    assign err      = r_err;
    assign wr_ready = (r_state == ST_WR_DATA) && axi_miso_if.wready;
    assign rd_valid = (r_state == ST_RD_DATA) && axi_miso_if.rvalid;
    assign rd_data  = axi_miso_if.rdata;

    // Address/len come from the latched copy so they hold steady while AxVALID waits.
    always_comb begin
        axi_mosi_if         = '0;
        axi_mosi_if.awid    = c_mst_id;
        axi_mosi_if.awaddr  = r_addr;
        axi_mosi_if.awlen   = r_len;
        axi_mosi_if.awsize  = c_axsize;
        axi_mosi_if.awburst = AXI_INCR;
        axi_mosi_if.awvalid = (r_state == ST_WR_ADDR);
        axi_mosi_if.wdata   = wr_data;
        axi_mosi_if.wstrb   = '1;
        axi_mosi_if.wlast   = (r_state == ST_WR_DATA) && w_last_beat;
        axi_mosi_if.wvalid  = (r_state == ST_WR_DATA) && wr_valid;
        axi_mosi_if.bready  = (r_state == ST_WR_RESP);
        axi_mosi_if.arid    = c_mst_id;
        axi_mosi_if.araddr  = r_addr;
        axi_mosi_if.arlen   = r_len;
        axi_mosi_if.arsize  = c_axsize;
        axi_mosi_if.arburst = AXI_INCR;
        axi_mosi_if.arvalid = (r_state == ST_RD_ADDR);
        axi_mosi_if.rready  = (r_state == ST_RD_DATA) && rd_ready;
    end

endmodule
`default_nettype wire

// File: tb/tb_ravenoc_pe_axi_mst.sv
`default_nettype none
// ============================================================================
// Module      : tb_ravenoc_pe_axi_mst
// Description : Self-checking bench with a transaction-level AXI slave model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ravenoc_pe_axi_mst;
    import ravenoc_pkg::*;

    localparam int                      TB_MST_ID = 2;
    localparam logic [AXI_ID_WIDTH-1:0] TB_ID     = AXI_ID_WIDTH'(TB_MST_ID);
    localparam logic [2:0]              TB_SIZE   = 3'($clog2(AXI_DATA_WIDTH/8));

    logic                      clk_axi = 1'b0;
    logic                      arst_axi;
    logic                      cmd_valid, cmd_ready, cmd_wr;
    logic [AXI_ADDR_WIDTH-1:0] cmd_addr;
    logic [7:0]                cmd_len;
    logic [AXI_DATA_WIDTH-1:0] wr_data, rd_data;
    logic                      wr_valid, wr_ready, rd_valid, rd_ready, done, err;
    s_axi_mosi_t               axi_mosi;
    s_axi_miso_t               axi_miso;
    logic [AXI_DATA_WIDTH/8-1:0] all_strb = '1;

    int checks   = 0;
    int failures = 0;

    always #5 clk_axi = ~clk_axi;

    ravenoc_pe_axi_mst #(.MST_ID(TB_MST_ID)) dut (
        .clk_axi    (clk_axi),
        .arst_axi   (arst_axi),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_wr     (cmd_wr),
        .cmd_addr   (cmd_addr),
        .cmd_len    (cmd_len),
        .wr_data    (wr_data),
        .wr_valid   (wr_valid),
        .wr_ready   (wr_ready),
        .rd_data    (rd_data),
        .rd_valid   (rd_valid),
        .rd_ready   (rd_ready),
        .done       (done),
        .err        (err),
        .axi_mosi_if(axi_mosi),
        .axi_miso_if(axi_miso)
    );

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic issue_cmd(input bit wr, input logic [31:0] a, input int len);
        @(posedge clk_axi); #1;
        cmd_valid = 1'b1; cmd_wr = wr; cmd_addr = a; cmd_len = 8'(len);
        #1;
        checks++;
        if (cmd_ready !== 1'b1) begin
            failures++;
            $display("FAIL cmd_ready_idle: got %b want 1", cmd_ready);
        end
        @(posedge clk_axi); #1;
        // Scramble the command bus so only latched values can pass the checks.
        cmd_valid = 1'b0; cmd_addr = $urandom; cmd_len = 8'($urandom);
    endtask

    task automatic run_write(input logic [31:0] addr, input int len, input logic [1:0] bresp,
                             input logic [AXI_ID_WIDTH-1:0] bid, input bit rnd);
        logic [AXI_DATA_WIDTH-1:0] beats[$];
        bit aw_done = 0, b_done = 0, done_seen = 0, in_w, exp_err;
        int wb = 0;
        logic [8:0] obs, exp;
        exp_err = (bresp != 2'b00);
`ifdef RAVENOC_PE_MST_CHECK_EN
        if (bid != TB_ID) exp_err = 1'b1;
`endif
        for (int i = 0; i <= len; i++) beats.push_back($urandom);
        issue_cmd(1'b1, addr, len);
        for (int cyc = 0; cyc < 4000 && !done_seen; cyc++) begin
            axi_miso         = '0;
            axi_miso.awready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            axi_miso.wready  = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            axi_miso.bvalid  = (wb > len) && (rnd ? 1'($urandom_range(0, 1)) : 1'b1);
            axi_miso.bresp   = bresp;
            axi_miso.bid     = bid;
            axi_miso.rvalid  = 1'($urandom_range(0, 1));
            wr_valid = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            wr_data  = (wb <= len) ? beats[wb] : $urandom;
            rd_ready = 1'($urandom_range(0, 1));
            #1;
            in_w = aw_done && (wb <= len);
            obs = {axi_mosi.awvalid, axi_mosi.wvalid, wr_ready, axi_mosi.bready, done, cmd_ready,
                   axi_mosi.arvalid, axi_mosi.rready, rd_valid};
            exp = {!aw_done, in_w && wr_valid, in_w && axi_miso.wready,
                   aw_done && (wb > len) && !b_done, b_done, 1'b0, 1'b0, 1'b0, 1'b0};
            checks++;
            if (obs !== exp) begin
                failures++;
                $display("FAIL wr_ctrl cyc%0d: got %b want %b", cyc, obs, exp);
            end
            if (axi_mosi.awvalid === 1'b1) begin
                checks++;
                if ({axi_mosi.awaddr, axi_mosi.awlen, axi_mosi.awsize, axi_mosi.awburst, axi_mosi.awid}
                    !== {addr, 8'(len), TB_SIZE, 2'b01, TB_ID}) begin
                    failures++;
                    $display("FAIL aw_fields: got %h/%0d/%0d/%0d/%0d want %h/%0d/%0d/1/%0d",
                             axi_mosi.awaddr, axi_mosi.awlen, axi_mosi.awsize, axi_mosi.awburst,
                             axi_mosi.awid, addr, len, TB_SIZE, TB_ID);
                end
            end
            if (axi_mosi.wvalid === 1'b1 && axi_miso.wready && in_w) begin
                checks++;
                if ({axi_mosi.wdata, axi_mosi.wstrb, axi_mosi.wlast} !== {beats[wb], all_strb, wb == len}) begin
                    failures++;
                    $display("FAIL w_beat%0d: got %h/%h/%b want %h/%h/%b", wb, axi_mosi.wdata,
                             axi_mosi.wstrb, axi_mosi.wlast, beats[wb], all_strb, wb == len);
                end
                wb++;
            end
            if (done === 1'b1) begin
                done_seen = 1;
                checks++;
                if (err !== exp_err) begin
                    failures++;
                    $display("FAIL wr_err: got %b want %b", err, exp_err);
                end
            end
            if (axi_mosi.awvalid === 1'b1 && axi_miso.awready) aw_done = 1;
            if (axi_mosi.bready === 1'b1 && axi_miso.bvalid) b_done = 1;
            if (!done_seen) begin @(posedge clk_axi); #1; end
        end
        checks++;
        if (!done_seen) begin
            failures++;
            $display("FAIL wr_timeout: done got 0 want 1 (beats %0d)", wb);
        end
        @(posedge clk_axi); #1;
        checks++;
        if ({done, cmd_ready} !== 2'b01) begin
            failures++;
            $display("FAIL wr_after_done: got %b want 01", {done, cmd_ready});
        end
    endtask

    task automatic run_read(input logic [31:0] addr, input int len, input int nbeats, input int bad_beat,
                            input logic [AXI_ID_WIDTH-1:0] rid, input int mode, input bit rnd);
        logic [AXI_DATA_WIDTH-1:0] rbeats[$];
        bit ar_done = 0, fin = 0, done_seen = 0, in_r, exp_err;
        int rb = 0;
        logic [8:0] obs, exp;
        exp_err = (bad_beat >= 0) && (bad_beat < nbeats);
`ifdef RAVENOC_PE_MST_CHECK_EN
        if (rid != TB_ID) exp_err = 1'b1;
        if (nbeats != len + 1) exp_err = 1'b1;
`endif
        for (int i = 0; i < nbeats; i++) rbeats.push_back($urandom);
        issue_cmd(1'b0, addr, len);
        for (int cyc = 0; cyc < 4000 && !done_seen; cyc++) begin
            axi_miso         = '0;
            axi_miso.arready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            axi_miso.rvalid  = ar_done && (rb < nbeats) && (rnd ? 1'($urandom_range(0, 1)) : 1'b1);
            axi_miso.rdata   = (rb < nbeats) ? rbeats[rb] : $urandom;
            axi_miso.rresp   = (rb == bad_beat) ? 2'b10 : 2'b00;
            axi_miso.rlast   = (rb == nbeats - 1);
            axi_miso.rid     = rid;
            axi_miso.wready  = 1'($urandom_range(0, 1));
            wr_valid = 1'($urandom_range(0, 1));
            rd_ready = (mode == 0) ? 1'b1 : (mode == 1) ? cyc[0] : 1'($urandom_range(0, 1));
            #1;
            in_r = ar_done && (rb < nbeats);
            obs = {axi_mosi.arvalid, axi_mosi.rready, rd_valid, done, cmd_ready,
                   axi_mosi.awvalid, axi_mosi.wvalid, wr_ready, axi_mosi.bready};
            exp = {!ar_done, in_r && rd_ready, in_r && axi_miso.rvalid, fin, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
            checks++;
            if (obs !== exp) begin
                failures++;
                $display("FAIL rd_ctrl cyc%0d: got %b want %b", cyc, obs, exp);
            end
            if (axi_mosi.arvalid === 1'b1) begin
                checks++;
                if ({axi_mosi.araddr, axi_mosi.arlen, axi_mosi.arsize, axi_mosi.arburst, axi_mosi.arid}
                    !== {addr, 8'(len), TB_SIZE, 2'b01, TB_ID}) begin
                    failures++;
                    $display("FAIL ar_fields: got %h/%0d/%0d/%0d/%0d want %h/%0d/%0d/1/%0d",
                             axi_mosi.araddr, axi_mosi.arlen, axi_mosi.arsize, axi_mosi.arburst,
                             axi_mosi.arid, addr, len, TB_SIZE, TB_ID);
                end
            end
            if (in_r && axi_miso.rvalid && rd_ready) begin
                checks++;
                if (rd_data !== rbeats[rb]) begin
                    failures++;
                    $display("FAIL r_beat%0d: got %h want %h", rb, rd_data, rbeats[rb]);
                end
                rb++;
                if (rb == nbeats) fin = 1;
            end
            if (done === 1'b1) begin
                done_seen = 1;
                checks++;
                if (err !== exp_err) begin
                    failures++;
                    $display("FAIL rd_err: got %b want %b", err, exp_err);
                end
            end
            if (axi_mosi.arvalid === 1'b1 && axi_miso.arready) ar_done = 1;
            if (!done_seen) begin @(posedge clk_axi); #1; end
        end
        checks++;
        if (!done_seen || rb != nbeats) begin
            failures++;
            $display("FAIL rd_timeout: beats %0d want %0d, done_seen %b want 1", rb, nbeats, done_seen);
        end
        @(posedge clk_axi); #1;
        checks++;
        if ({done, cmd_ready} !== 2'b01) begin
            failures++;
            $display("FAIL rd_after_done: got %b want 01", {done, cmd_ready});
        end
    endtask

    task automatic test_reset();
        arst_axi = 1'b1;
        cmd_valid = 1'b0; cmd_wr = 1'b0; cmd_addr = '0; cmd_len = '0;
        wr_data = '0; wr_valid = 1'b1; rd_ready = 1'b1;
        axi_miso = '0; axi_miso.wready = 1'b1; axi_miso.rvalid = 1'b1;
        repeat (2) @(posedge clk_axi);
        #1;
        checks++;
        if ({axi_mosi.awvalid, axi_mosi.arvalid, axi_mosi.wvalid, axi_mosi.bready, axi_mosi.rready,
             done, err, wr_ready, rd_valid} !== 9'b0) begin
            failures++;
            $display("FAIL reset_outputs: got %b want 000000000",
                     {axi_mosi.awvalid, axi_mosi.arvalid, axi_mosi.wvalid, axi_mosi.bready,
                      axi_mosi.rready, done, err, wr_ready, rd_valid});
        end
        arst_axi = 1'b0;
        #1;
        checks++;
        if (cmd_ready !== 1'b1) begin
            failures++;
            $display("FAIL reset_cmd_ready: got %b want 1", cmd_ready);
        end
    endtask

    task automatic test_write_basic();
        run_write(32'h1000, 3, 2'b00, TB_ID, 1'b0);
    endtask

    task automatic test_read_single();
        run_read(32'h2000, 0, 1, -1, TB_ID, 0, 1'b0);
    endtask

    task automatic test_write_slverr();
        run_write(32'h1100, 2, 2'b10, TB_ID, 1'b0);
        checks++;
        if (err !== 1'b1) begin
            failures++;
            $display("FAIL err_held_idle: got %b want 1", err);
        end
        run_write(32'h1200, 1, 2'b00, TB_ID, 1'b0);
    endtask

    task automatic test_read_toggle();
        run_read(32'h3000, 7, 8, -1, TB_ID, 1, 1'b0);
    endtask

    task automatic test_random();
        for (int t = 0; t < 12; t++) begin
            int len = $urandom_range(0, 15);
            if ($urandom_range(0, 1) == 1) begin
                run_write($urandom, len, ($urandom_range(0, 3) == 0) ? 2'b11 : 2'b00, TB_ID, 1'b1);
            end else begin
                run_read($urandom, len, len + 1,
                         ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, len)) : -1, TB_ID, 2, 1'b1);
            end
        end
    endtask

    task automatic test_boundary_len255();
        run_write(32'h4000, 255, 2'b00, TB_ID, 1'b0);
        run_read(32'h5000, 255, 256, 255, TB_ID, 0, 1'b0);
    endtask

    task automatic test_reset_mid_burst();
        issue_cmd(1'b1, 32'h6000, 5);
        axi_miso = '0; axi_miso.awready = 1'b1; axi_miso.wready = 1'b1;
        wr_valid = 1'b1; wr_data = $urandom;
        @(posedge clk_axi); #1;
        @(posedge clk_axi); #1;
        checks++;
        if (axi_mosi.wvalid !== 1'b1) begin
            failures++;
            $display("FAIL mid_burst_wvalid: got %b want 1", axi_mosi.wvalid);
        end
        arst_axi = 1'b1;
        #1;
        checks++;
        if ({axi_mosi.wvalid, wr_ready, done, axi_mosi.awvalid, axi_mosi.bready} !== 5'b0) begin
            failures++;
            $display("FAIL rst_drop: got %b want 00000",
                     {axi_mosi.wvalid, wr_ready, done, axi_mosi.awvalid, axi_mosi.bready});
        end
        for (int i = 0; i < 3; i++) begin
            @(posedge clk_axi); #1;
            checks++;
            if (done !== 1'b0) begin
                failures++;
                $display("FAIL rst_no_done: got %b want 0", done);
            end
        end
        arst_axi = 1'b0;
        #1;
        checks++;
        if ({cmd_ready, axi_mosi.wvalid, done, err} !== 4'b1000) begin
            failures++;
            $display("FAIL rst_release: got %b want 1000", {cmd_ready, axi_mosi.wvalid, done, err});
        end
        wr_valid = 1'b0;
        run_write(32'h6100, 2, 2'b00, TB_ID, 1'b1);
    endtask

`ifdef RAVENOC_PE_MST_CHECK_EN
    task automatic test_checks();
        run_read(32'h7000, 3, 2, -1, TB_ID, 0, 1'b0);
        run_read(32'h7100, 3, 5, -1, TB_ID, 0, 1'b0);
        run_read(32'h7200, 1, 2, -1, 4'd1, 0, 1'b0);
        run_write(32'h7300, 1, 2'b00, 4'd1, 1'b0);
        run_read(32'h7400, 3, 4, -1, TB_ID, 0, 1'b0);
    endtask
`endif

    initial begin
        test_reset();
        test_write_basic();
        test_read_single();
        test_write_slverr();
        test_read_toggle();
        test_random();
        test_boundary_len255();
        test_reset_mid_burst();
`ifdef RAVENOC_PE_MST_CHECK_EN
        test_checks();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/ravenoc_pe_axi_mst.md
RAVENOC_PE_AXI_MST -- requirements
Module: ravenoc_pe_axi_mst

Interface
REQ-001 The block SHALL have parameter MST_ID, default 0, giving the AXI ID driven on AWID and ARID.
REQ-002 The block SHALL take AXI widths (AXI_ADDR_WIDTH, AXI_DATA_WIDTH) and the AXI struct types from ravenoc_pkg.
REQ-003 The block SHALL have the following ports:
- clk_axi  input  1  Sole clock.
- arst_axi  input  1  Reset; one clock; reset is asynchronous and active-high.
- cmd_valid  input  1  Command request.
- cmd_ready  output  1  Command accepted when both high.
- cmd_wr  input  1  1 = burst write (send packet into NI); 0 = burst read (drain NI RX).
- cmd_addr  input  AXI_ADDR_WIDTH  Start address (NI CSR/buffer).
- cmd_len  input  8  Beats minus one.
- wr_data  input  AXI_DATA_WIDTH  Write beat payload.
- wr_valid / wr_ready  input / output  1 / 1  Write-beat stream handshake.
- rd_data  output  AXI_DATA_WIDTH  Read beat payload.
- rd_valid / rd_ready  output / input  1 / 1  Read-beat stream handshake.
- done  output  1  One-cycle completion pulse.
- err  output  1  Status, valid with done.
- axi_mosi_if  output  s_axi_mosi_t  AXI master outputs toward NI slave.
- axi_miso_if  input  s_axi_miso_t  AXI slave responses.

Function
REQ-004 The FSM SHALL have states IDLE, WR_ADDR, WR_DATA, WR_RESP, RD_ADDR, RD_DATA, DONE.
REQ-005 In IDLE, cmd_ready SHALL be 1; on cmd_valid&cmd_ready, addr/len/wr SHALL be latched and the FSM SHALL move to WR_ADDR or RD_ADDR; in all other states cmd_ready SHALL be 0.
REQ-006 In WR_ADDR/RD_ADDR, AWVALID/ARVALID SHALL be 1 with AxADDR=latched addr, AxLEN=latched len, AxSIZE=log2(AXI_DATA_WIDTH/8), AxBURST=INCR, AxID=MST_ID, all stable until AxREADY; the handshake SHALL move the FSM to WR_DATA/RD_DATA.
REQ-007 In WR_DATA: WVALID=wr_valid, wr_ready=WREADY, WDATA=wr_data, WSTRB all ones; WLAST SHALL be 1 when the beat counter equals len; the handshake with WLAST SHALL move the FSM to WR_RESP. Outside WR_DATA, WVALID and wr_ready SHALL be 0.
REQ-008 In WR_RESP, BREADY SHALL be 1; BVALID SHALL move the FSM to DONE and set err if BRESP != OKAY.
REQ-009 In RD_DATA: rd_valid=RVALID, RREADY=rd_ready, rd_data=RDATA; each handshake SHALL increment the counter; RRESP != OKAY on any beat SHALL set err sticky; the beat with RLAST SHALL move the FSM to DONE. Outside RD_DATA, RREADY and rd_valid SHALL be 0.
REQ-010 DONE SHALL last exactly one cycle with done=1 and err valid, then return to IDLE; err SHALL clear on the next command accept.
REQ-011 The beat counter SHALL be 8 bits, cleared on command accept; len=0 SHALL give a single beat with WLAST on the first beat; len=255 SHALL give 256 beats without wrap-around before the last beat.
REQ-012 Only one transaction SHALL be outstanding; no simultaneous AW/W issue.

Reset
REQ-013 On arst_axi high, the FSM SHALL go to IDLE asynchronously, with all AXI VALID/READY outputs, done, err, wr_ready, and rd_valid at 0, counter and latched fields at 0, and cmd_ready at 1 once arst_axi is low.
REQ-014 Reset mid-burst SHALL abandon the transaction with no done pulse.

Configuration
REQ-015 When RAVENOC_PE_MST_CHECK_EN is defined, err SHALL also be set if BID/RID != MST_ID, or if RLAST arrives on a beat other than count==len, or if count reaches len without RLAST (the FSM still waits for RLAST). When it is undefined, none of these checks SHALL exist and err SHALL reflect BRESP/RRESP only.

Verification
REQ-016 Write with addr=0x1000, len=3, wr_valid held high, slave always ready -> AW at 0x1000 with AWLEN=3, 4 W beats with WLAST on beat 4, BRESP=OKAY, then done=1 and err=0.
REQ-017 Read with len=0 and rd_ready=1 -> single R beat with RLAST, rd_data equals RDATA, done on the following cycle.
REQ-018 Write where the slave returns BRESP=SLVERR -> done=1 and err=1; a following OKAY write -> err=0.
REQ-019 Read with len=7 where rd_ready toggles every other cycle -> RREADY mirrors rd_ready, 8 beats accepted, no data lost.
REQ-020 arst_axi asserted during WR_DATA beat 2 -> WVALID drops immediately, no done pulse, and cmd_ready=1 after release.
REQ-021 With RAVENOC_PE_MST_CHECK_EN defined: read len=3 with RLAST on beat 2 -> done, err=1; with MST_ID=2 and RID=1 -> err=1.
